// File: rtl/mem_controller.sv
// Single-bank memory controller: pops one request from the request FIFO, performs the
// access on local word storage and pushes a {TID, data} response. One request in flight.
module mem_controller #(
  parameter int MODULE_NUM   = 0,
  parameter int MODULE_WIDTH = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 31,
  parameter int TID_WIDTH    = 16,
  parameter int MEM_DEPTH    = 256,
  localparam int REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH,
  localparam int RSP_W = TID_WIDTH + DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic             read_ctr,
  input  logic [REQ_W-1:0] incoming_data,
  input  logic             empty_signal,
  output logic             write_ctr,
  output logic [RSP_W-1:0] outgoing_data,
  input  logic             full_signal
);

  localparam int SHIFT = $clog2(MODULE_WIDTH);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    CAPT = 3'd2,
    ACC  = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t state, state_n;
  logic   read_n, write_n, capt_en, acc_en;

  logic [TID_WIDTH-1:0]  tid_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  // Banks are word-interleaved: drop the bank-select bits, keep only the index bits.
  assign idx = addr_q[SHIFT +: IDX_W];

  logic        unused_addr;
  logic [31:0] unused_bank_id;
  assign unused_addr    = ^addr_q;
  assign unused_bank_id = MODULE_NUM;

  always_comb begin
    state_n = state;
    read_n  = 1'b0;
    write_n = 1'b0;
    capt_en = 1'b0;
    acc_en  = 1'b0;
    case (state)
      IDLE: if (!empty_signal) begin
        read_n  = 1'b1;
        state_n = POP;
      end
      POP:  state_n = CAPT;
      CAPT: begin
        capt_en = 1'b1;
        state_n = ACC;
      end
      ACC: begin
        acc_en  = 1'b1;
        state_n = RSP;
      end
      RSP: if (!full_signal) begin
        write_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      read_ctr      <= 1'b0;
      write_ctr     <= 1'b0;
      outgoing_data <= '0;
    end else begin
      state     <= state_n;
      read_ctr  <= read_n;
      write_ctr <= write_n;
      if (write_n) outgoing_data <= {tid_q, rsp_q};
    end
  end

  // Reset gates the access so a request caught mid-flight leaves no trace in memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (capt_en) begin
        tid_q  <= incoming_data[REQ_W-1 -: TID_WIDTH];
        rw_q   <= incoming_data[ADDR_WIDTH+DATA_WIDTH];
        addr_q <= incoming_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        data_q <= incoming_data[DATA_WIDTH-1:0];
      end
      if (acc_en) begin
        if (rw_q) begin
          mem[idx] <= data_q;
          rsp_q    <= data_q;
        end else begin
          rsp_q    <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: the bench plays both FIFOs and checks pops, pushes,
// response contents and handshake timing against hand-computed values.
module tb_mem_controller;
  localparam int REQ_W = 80;
  localparam int RSP_W = 48;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             read_ctr;
  logic [REQ_W-1:0] incoming_data = '0;
  logic             empty_signal = 1'b1;
  logic             write_ctr;
  logic [RSP_W-1:0] outgoing_data;
  logic             full_signal = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_controller dut (
    .clk(clk), .reset(reset), .read_ctr(read_ctr), .incoming_data(incoming_data),
    .empty_signal(empty_signal), .write_ctr(write_ctr), .outgoing_data(outgoing_data),
    .full_signal(full_signal)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk(input logic [15:0] tid, input logic rw,
                                          input logic [30:0] addr, input logic [31:0] data);
    return {tid, rw, addr, data};
  endfunction

  // Presents one request, waits for the pop and the push; reports what it saw.
  task automatic issue(input logic [REQ_W-1:0] req, output logic ok, output logic [RSP_W-1:0] rsp,
                       output int lat, output int rd_width, output int wr_width);
    ok = 1'b0; rsp = '0; lat = 0; rd_width = 0; wr_width = 0;
    @(negedge clk);
    incoming_data = req;
    empty_signal  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_ctr) begin
        rd_width = 1;
        lat = 1;
        break;
      end
    end
    empty_signal = 1'b1;
    if (rd_width == 0) return;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (read_ctr) rd_width++;
      if (write_ctr) begin
        ok = 1'b1;
        rsp = outgoing_data;
        wr_width = 1;
        break;
      end
    end
    if (!ok) return;
    @(negedge clk);
    if (write_ctr) wr_width++;
  endtask

  task automatic test_reset();
    int pops;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (read_ctr !== 1'b0) begin errors++; $display("FAIL reset_read_ctr got=%b exp=0", read_ctr); end
    checks++; if (write_ctr !== 1'b0) begin errors++; $display("FAIL reset_write_ctr got=%b exp=0", write_ctr); end
    checks++; if (outgoing_data !== '0) begin errors++; $display("FAIL reset_outgoing got=%h exp=0", outgoing_data); end
    reset = 1'b0;
    pops = 0;
    repeat (20) begin
      @(negedge clk);
      if (read_ctr !== 1'b0) pops++;
    end
    checks++; if (pops != 0) begin errors++; $display("FAIL idle_empty_pops got=%0d exp=0", pops); end
  endtask

  task automatic test_write_read();
    logic ok; logic [RSP_W-1:0] rsp; int lat, rdw, wrw;
    issue(mk(16'd1, 1'b1, 31'd15, 32'd7), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok) begin errors++; $display("FAIL wr_timeout got=no_push exp=push"); end
    checks++; if (rsp !== {16'd1, 32'd7}) begin errors++; $display("FAIL wr_rsp got=%h exp=%h", rsp, {16'd1, 32'd7}); end
    checks++; if (lat != 5) begin errors++; $display("FAIL wr_latency got=%0d exp=5", lat); end
    checks++; if (rdw != 1) begin errors++; $display("FAIL wr_pop_width got=%0d exp=1", rdw); end
    checks++; if (wrw != 1) begin errors++; $display("FAIL wr_push_width got=%0d exp=1", wrw); end
    issue(mk(16'd2, 1'b0, 31'd15, 32'hDEAD_BEEF), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok) begin errors++; $display("FAIL rd_timeout got=no_push exp=push"); end
    checks++; if (rsp !== {16'd2, 32'd7}) begin errors++; $display("FAIL rd_rsp got=%h exp=%h", rsp, {16'd2, 32'd7}); end
    checks++; if (rdw != 1) begin errors++; $display("FAIL rd_pop_width got=%0d exp=1", rdw); end
    repeat (4) @(negedge clk);
    checks++; if (outgoing_data !== {16'd2, 32'd7}) begin errors++; $display("FAIL rsp_hold got=%h exp=%h", outgoing_data, {16'd2, 32'd7}); end
  endtask

  task automatic test_unwritten();
    logic ok; logic [RSP_W-1:0] rsp; int lat, rdw, wrw;
    issue(mk(16'd3, 1'b0, 31'd40, 32'h0), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok || rsp !== {16'd3, 32'd0}) begin errors++; $display("FAIL unwritten_rsp got=%h ok=%b exp=%h", rsp, ok, {16'd3, 32'd0}); end
  endtask

  task automatic test_back_pressure();
    int seen, bad;
    full_signal = 1'b1;
    @(negedge clk);
    incoming_data = mk(16'd4, 1'b0, 31'd15, 32'h0);
    empty_signal  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (read_ctr) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL bp_pop got=%0d exp=1", seen); end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (write_ctr !== 1'b0 || read_ctr !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_strobes got=%0d exp=0", bad); end
    full_signal  = 1'b0;
    empty_signal = 1'b1;
    @(negedge clk);
    checks++; if (write_ctr !== 1'b1) begin errors++; $display("FAIL bp_release_push got=%b exp=1", write_ctr); end
    checks++; if (outgoing_data !== {16'd4, 32'd7}) begin errors++; $display("FAIL bp_rsp got=%h exp=%h", outgoing_data, {16'd4, 32'd7}); end
    @(negedge clk);
    checks++; if (write_ctr !== 1'b0) begin errors++; $display("FAIL bp_push_width got=%b exp=0", write_ctr); end
  endtask

  task automatic test_wrap();
    logic ok; logic [RSP_W-1:0] rsp; int lat, rdw, wrw;
    issue(mk(16'd5, 1'b1, 31'h1FE, 32'hA5), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok || rsp !== {16'd5, 32'hA5}) begin errors++; $display("FAIL wrap_wr got=%h exp=%h", rsp, {16'd5, 32'hA5}); end
    issue(mk(16'd6, 1'b0, 31'h1FF, 32'h0), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok || rsp !== {16'd6, 32'hA5}) begin errors++; $display("FAIL wrap_rd got=%h exp=%h", rsp, {16'd6, 32'hA5}); end
    issue(mk(16'd7, 1'b0, 31'h4000_01FF, 32'h0), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok || rsp !== {16'd7, 32'hA5}) begin errors++; $display("FAIL wrap_high_bits got=%h exp=%h", rsp, {16'd7, 32'hA5}); end
  endtask

  task automatic test_reset_midop();
    logic ok; logic [RSP_W-1:0] rsp; int lat, rdw, wrw, seen, pushes;
    @(negedge clk);
    incoming_data = mk(16'd8, 1'b0, 31'd15, 32'h0);
    empty_signal  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (read_ctr) seen = 1;
    end
    empty_signal = 1'b1;
    checks++; if (seen != 1) begin errors++; $display("FAIL midop_pop got=%0d exp=1", seen); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (outgoing_data !== '0) begin errors++; $display("FAIL midop_outgoing got=%h exp=0", outgoing_data); end
    pushes = 0;
    repeat (10) begin
      @(negedge clk);
      if (write_ctr) pushes++;
    end
    checks++; if (pushes != 0) begin errors++; $display("FAIL midop_no_push got=%0d exp=0", pushes); end
    issue(mk(16'd9, 1'b0, 31'd15, 32'h0), ok, rsp, lat, rdw, wrw);
    checks++; if (!ok || rsp !== {16'd9, 32'd7}) begin errors++; $display("FAIL midop_next_rsp got=%h exp=%h", rsp, {16'd9, 32'd7}); end
    checks++; if (lat != 5) begin errors++; $display("FAIL midop_next_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_back_to_back();
    int first, second, pushes;
    @(negedge clk);
    incoming_data = mk(16'd10, 1'b0, 31'd15, 32'h0);
    empty_signal  = 1'b0;
    first = -1; second = -1; pushes = 0;
    for (int i = 0; i < 20 && second < 0; i++) begin
      @(negedge clk);
      if (write_ctr) pushes++;
      if (read_ctr) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    empty_signal = 1'b1;
    checks++; if (second - first != 5 || first < 0) begin errors++; $display("FAIL b2b_interval got=%0d exp=5", second - first); end
    repeat (10) begin
      @(negedge clk);
      if (write_ctr) pushes++;
    end
    checks++; if (pushes != 2) begin errors++; $display("FAIL b2b_pushes got=%0d exp=2", pushes); end
    checks++; if (outgoing_data !== {16'd10, 32'd7}) begin errors++; $display("FAIL b2b_rsp got=%h exp=%h", outgoing_data, {16'd10, 32'd7}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_back_pressure();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
